// File: rtl/fp16_unpack_stage.sv
// fp16_unpack_stage
//   Registered unpack stage for IEEE-754 binary16 operands. Sits ahead of the
//   adder/multiplier front end and hands it sign, unbiased exponent, mantissa
//   with an explicit hidden bit, and a one-hot class vector. Subnormals are
//   normalised one bit per cycle, so consumers only ever see normalised values.
//
// Handshake: a word moves on a rising edge when valid & ready are both high on
//   that side. A source may not retract valid once raised and must hold its
//   data until it is taken. The stage holds every out_* stable while
//   out_valid & !out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   stage can accept in_data this cycle
//   in_data    binary16 word {sign, exp[14:10], frac[9:0]}
//   out_valid  unpacked result is valid
//   out_ready  consumer accepts the result
//   out_sign   sign bit, passed through for every class
//   out_exp    signed unbiased exponent (two's complement)
//   out_mant   mantissa, bit 10 is the hidden bit
//   out_class  one-hot {qnan, snan, zero, inf, normal, subnormal}
//   busy       high while a subnormal is being normalised
//
// Parameters
//   NORM_SUBNORMAL  1: normalise subnormals over several cycles
//                   0: pass them through as exp=-14, mant={0,frac}
//   QUIET_SNAN      1: set mantissa bit 9 on sNaN inputs (class still sNaN)

module fp16_unpack_stage #(
    parameter bit NORM_SUBNORMAL = 1'b1,
    parameter bit QUIET_SNAN     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [6:0]  out_exp,
    output logic [10:0] out_mant,
    output logic [5:0]  out_class,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [6:0] EXP_SPECIAL = 7'd16;   // inf / NaN
    localparam logic [6:0] EXP_SUBMIN  = 7'h72;   // -14

    localparam logic [5:0] CLS_QNAN = 6'b100000;
    localparam logic [5:0] CLS_SNAN = 6'b010000;
    localparam logic [5:0] CLS_ZERO = 6'b001000;
    localparam logic [5:0] CLS_INF  = 6'b000100;
    localparam logic [5:0] CLS_NORM = 6'b000010;
    localparam logic [5:0] CLS_SUB  = 6'b000001;

    state_t      state;

    logic [4:0]  in_ef;
    logic [9:0]  in_frac;
    logic [6:0]  ld_exp;
    logic [10:0] ld_mant;
    logic [5:0]  ld_class;
    logic        ld_norm;
    logic        accept;

    assign in_ef   = in_data[14:10];
    assign in_frac = in_data[9:0];

    // Decode of the incoming word into the values loaded on accept.
    always_comb begin
        ld_exp   = '0;
        ld_mant  = '0;
        ld_class = '0;
        ld_norm  = 1'b0;
        if (in_ef == 5'h1F) begin
            ld_exp  = EXP_SPECIAL;
            ld_mant = {1'b0, in_frac};
            if (in_frac == 10'd0) begin
                ld_class = CLS_INF;
            end else if (in_frac[9]) begin
                ld_class = CLS_QNAN;
            end else begin
                ld_class = CLS_SNAN;
                if (QUIET_SNAN) begin
                    ld_mant[9] = 1'b1;
                end
            end
        end else if (in_ef == 5'h00) begin
            if (in_frac == 10'd0) begin
                ld_class = CLS_ZERO;
            end else begin
                ld_class = CLS_SUB;
                ld_exp   = EXP_SUBMIN;
                ld_mant  = {1'b0, in_frac};
                ld_norm  = NORM_SUBNORMAL;
            end
        end else begin
            ld_class = CLS_NORM;
            ld_exp   = {2'b00, in_ef} - 7'd15;
            ld_mant  = {1'b1, in_frac};
        end
    end

    // Gated by rst_n so the source sees not-ready for the whole reset window.
    assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_class <= '0;
        end else begin
            case (state)
                IDLE: ;
                NORM: begin
                    out_mant <= out_mant << 1;
                    out_exp  <= out_exp - 7'd1;
                    // Bit 9 now becomes the hidden bit after this shift.
                    if (out_mant[9]) begin
                        state     <= HOLD;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready && !in_valid) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase

            // A new load wins over the HOLD drain so streaming has no bubble.
            if (accept) begin
                out_sign  <= in_data[15];
                out_exp   <= ld_exp;
                out_mant  <= ld_mant;
                out_class <= ld_class;
                if (ld_norm) begin
                    state     <= NORM;
                    busy      <= 1'b1;
                    out_valid <= 1'b0;
                end else begin
                    state     <= HOLD;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
